// File: rtl/alu_issue_reg.sv
// Registered ALU issue stage: decodes funct3/funct7_5 into one-hot ALU selects and
// muxes operand_b, with a 1-entry skid buffer so in_ready comes straight from a flop.
module alu_issue_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_is_rtype,
   input  logic [2:0]       in_funct3,
   input  logic             in_funct7_5,
   input  logic [WIDTH-1:0] in_rs1_data,
   input  logic [WIDTH-1:0] in_rs2_data,
   input  logic [WIDTH-1:0] in_imm,
   input  logic [4:0]       in_rd,
   input  logic             in_reg_write,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] operand_a,
   output logic [WIDTH-1:0] operand_b,
   output logic             alu_sel_add,
   output logic             alu_sel_sub,
   output logic             alu_sel_and,
   output logic             alu_sel_or,
   output logic             alu_sel_slt,
   output logic [4:0]       out_rd,
   output logic             out_reg_write,
   output logic             out_illegal
);

   typedef struct packed {
      logic             sel_add;
      logic             sel_sub;
      logic             sel_and;
      logic             sel_or;
      logic             sel_slt;
      logic             illegal;
      logic             reg_write;
      logic [4:0]       rd;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } op_t;

   op_t  dec_op;
   op_t  main_op;
   op_t  skid_op;
   logic main_valid;
   logic skid_valid;
   logic accept;
   logic drain;

   // NOTE: every field is given a default first so no path through the case leaves a latch.
   always_comb begin
      dec_op    = '0;
      dec_op.a  = in_rs1_data;
      dec_op.b  = in_is_rtype ? in_rs2_data : in_imm;
      dec_op.rd = in_rd;
      case (in_funct3)
         3'b000:  begin
            if (in_is_rtype && in_funct7_5) dec_op.sel_sub = 1'b1;
            else                            dec_op.sel_add = 1'b1;
         end
         3'b111:  dec_op.sel_and = 1'b1;
         3'b110:  dec_op.sel_or  = 1'b1;
         3'b010:  dec_op.sel_slt = 1'b1;
         default: dec_op.illegal = 1'b1;
      endcase
      // Bit 30 is only meaningful for ADD/SUB among the supported R-type ops.
      if (in_is_rtype && in_funct7_5 && in_funct3 != 3'b000) begin
         dec_op.sel_and = 1'b0;
         dec_op.sel_or  = 1'b0;
         dec_op.sel_slt = 1'b0;
         dec_op.illegal = 1'b1;
      end
      dec_op.reg_write = in_reg_write & ~dec_op.illegal;
   end

   assign in_ready = ~skid_valid;
   assign accept   = in_valid & in_ready & ~flush;
   assign drain    = main_valid & out_ready;

   // NOTE: payload registers are reset too, so every output reads 0 until the first accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_op    <= '0;
         skid_op    <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid || drain) begin
         // NOTE: non-blocking assignments so main and skid all update from pre-edge values.
         if (skid_valid) begin
            main_op    <= skid_op;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_op    <= dec_op;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_op    <= dec_op;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid     = main_valid;
   assign operand_a     = main_op.a;
   assign operand_b     = main_op.b;
   assign out_rd        = main_op.rd;
   assign out_reg_write = main_op.reg_write;
   assign out_illegal   = main_op.illegal;
   assign alu_sel_add   = main_valid & main_op.sel_add;
   assign alu_sel_sub   = main_valid & main_op.sel_sub;
   assign alu_sel_and   = main_valid & main_op.sel_and;
   assign alu_sel_or    = main_valid & main_op.sel_or;
   assign alu_sel_slt   = main_valid & main_op.sel_slt;

endmodule

// File: tb/tb_alu_issue_reg.sv
// Bench for alu_issue_reg: an in-order queue model of the ops held in the stage,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_alu_issue_reg;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_rtype;
   logic [2:0]  in_funct3;
   logic        in_funct7_5;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic [31:0] in_imm;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_illegal;

   alu_issue_reg #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_is_rtype(in_is_rtype), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .operand_a(operand_a), .operand_b(operand_b),
      .alu_sel_add(alu_sel_add), .alu_sel_sub(alu_sel_sub), .alu_sel_and(alu_sel_and),
      .alu_sel_or(alu_sel_or), .alu_sel_slt(alu_sel_slt),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Select vector order: {add, sub, and, or, slt}
   typedef struct packed {
      logic [4:0]  sel;
      logic        illegal;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   function automatic exp_t model_op(input logic rt, input logic [2:0] f3, input logic f7,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] imm, input logic [4:0] rd,
                                     input logic rw);
      exp_t e;
      logic legal;
      int   idx;
      legal = (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2) &&
              !(rt && f7 && f3 != 3'd0);
      idx = (f3 == 3'd0) ? ((rt && f7) ? 3 : 4) : (f3 == 3'd7) ? 2 : (f3 == 3'd6) ? 1 : 0;
      e.sel     = legal ? (5'b00001 << idx) : 5'b00000;
      e.illegal = !legal;
      e.rw      = rw && legal;
      e.rd      = rd;
      e.a       = rs1;
      e.b       = rt ? rs2 : imm;
      return e;
   endfunction

   exp_t       mq[$];
   logic [4:0] drained[$];

   // Model: the stage is an in-order FIFO of depth 2; in_ready means fewer than 2 held.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
      end else if (flush) begin
         mq.delete();
      end else begin
         logic acc;
         logic drn;
         acc = in_valid && (mq.size() < 2);
         drn = (mq.size() > 0) && out_ready;
         if (drn) void'(mq.pop_front());
         if (acc) mq.push_back(model_op(in_is_rtype, in_funct3, in_funct7_5, in_rs1_data,
                                        in_rs2_data, in_imm, in_rd, in_reg_write));
      end
   end

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready && !flush) drained.push_back(out_rd);
   end

   logic [4:0]  dut_sel;
   logic [76:0] snap_now;
   logic [76:0] snap_prev;
   logic        stalled = 1'b0;
   assign dut_sel  = {alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt};
   assign snap_now = {out_valid, operand_a, operand_b, out_rd, out_reg_write, out_illegal, dut_sel};

   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         check("out_valid", out_valid, mq.size() > 0);
         check("in_ready", in_ready, mq.size() < 2);
         if (out_valid && mq.size() > 0) begin
            check("sel", dut_sel, mq[0].sel);
            check("illegal", out_illegal, mq[0].illegal);
            check("reg_write", out_reg_write, mq[0].rw);
            check("rd", out_rd, mq[0].rd);
            check("operand_a", operand_a, mq[0].a);
            check("operand_b", operand_b, mq[0].b);
         end else begin
            check("sel_idle", dut_sel, 5'b0);
         end
         if (stalled) check("stall_hold", snap_now, snap_prev);
         snap_prev = snap_now;
         stalled   = out_valid && !out_ready && !flush;
      end
   end

   task automatic set_op(input logic rt, input logic [2:0] f3, input logic f7,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] rd, input logic rw);
      in_valid     = 1'b1;
      in_is_rtype  = rt;
      in_funct3    = f3;
      in_funct7_5  = f7;
      in_rs1_data  = rs1;
      in_rs2_data  = rs2;
      in_imm       = imm;
      in_rd        = rd;
      in_reg_write = rw;
   endtask

   // Presents one op and returns 1 time unit after the edge that accepts it.
   task automatic send(input logic rt, input logic [2:0] f3, input logic f7,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd, input logic rw);
      logic ok;
      ok = 1'b0;
      set_op(rt, f3, f7, rs1, rs2, imm, rd, rw);
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      check("send_accept", ok, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      set_op(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      in_valid = 1'b0;
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_operand_a", operand_a, 32'd0);
      check("rst_sel", dut_sel, 5'b0);
      step();
      rst_n = 1'b1;
      step();

      // ADD x3, rs1=5, rs2=7
      out_ready = 1'b1;
      send(1'b1, 3'b000, 1'b0, 32'd5, 32'd7, 32'd99, 5'd3, 1'b1);
      check("add_valid", out_valid, 1'b1);
      check("add_sel", dut_sel, 5'b10000);
      check("add_a", operand_a, 32'd5);
      check("add_b", operand_b, 32'd7);
      check("add_rd", out_rd, 5'd3);

      // SUB then ADDI with bit 30 set (ignored for I-type)
      send(1'b1, 3'b000, 1'b1, 32'd10, 32'd10, 32'd0, 5'd4, 1'b1);
      check("sub_sel", dut_sel, 5'b01000);
      send(1'b0, 3'b000, 1'b1, 32'd2, 32'd8, 32'hFFFF_FFFF, 5'd5, 1'b1);
      check("addi_sel", dut_sel, 5'b10000);
      check("addi_b", operand_b, 32'hFFFF_FFFF);
      step();

      // Backpressure: A to main, B to skid, C held upstream
      drained.delete();
      out_ready = 1'b0;
      send(1'b1, 3'b111, 1'b0, 32'hA0, 32'hA1, 32'h0, 5'd10, 1'b1);
      send(1'b0, 3'b110, 1'b0, 32'hB0, 32'hB1, 32'hB2, 5'd11, 1'b1);
      check("skid_in_ready", in_ready, 1'b0);
      check("stall_rd_a0", out_rd, 5'd10);
      set_op(1'b1, 3'b010, 1'b0, 32'hC0, 32'hC1, 32'h0, 5'd12, 1'b1);
      step();
      check("stall_rd_a1", out_rd, 5'd10);
      check("stall_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      step();
      check("release_rd_b", out_rd, 5'd11);
      check("release_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check("release_rd_c", out_rd, 5'd12);
      check("slt_sel", dut_sel, 5'b00001);
      step();
      check("order_count", drained.size(), 3);
      if (drained.size() == 3) begin
         check("order_0", drained[0], 5'd10);
         check("order_1", drained[1], 5'd11);
         check("order_2", drained[2], 5'd12);
      end

      // Illegal ops: SLL, and R-type AND with bit 30 set
      send(1'b1, 3'b001, 1'b0, 32'd1, 32'd2, 32'd0, 5'd6, 1'b1);
      check("sll_illegal", out_illegal, 1'b1);
      check("sll_sel", dut_sel, 5'b0);
      check("sll_reg_write", out_reg_write, 1'b0);
      send(1'b1, 3'b111, 1'b1, 32'd1, 32'd2, 32'd0, 5'd7, 1'b1);
      check("andf7_illegal", out_illegal, 1'b1);
      send(1'b0, 3'b101, 1'b0, 32'd3, 32'd0, 32'd4, 5'd8, 1'b1);
      step();

      // Flush with main and skid full plus a same-cycle input
      drained.delete();
      out_ready = 1'b0;
      send(1'b1, 3'b000, 1'b0, 32'd20, 32'd20, 32'd0, 5'd20, 1'b1);
      send(1'b1, 3'b000, 1'b0, 32'd21, 32'd21, 32'd0, 5'd21, 1'b1);
      set_op(1'b1, 3'b000, 1'b0, 32'd22, 32'd22, 32'd0, 5'd22, 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      check("flush_sel", dut_sel, 5'b0);
      out_ready = 1'b1;
      repeat (3) step();
      check("flush_nothing_out", drained.size(), 0);

      // Asynchronous reset in the middle of a stall
      out_ready = 1'b0;
      send(1'b1, 3'b110, 1'b0, 32'h1234, 32'h5678, 32'h0, 5'd25, 1'b1);
      send(1'b1, 3'b111, 1'b0, 32'h1, 32'h2, 32'h0, 5'd26, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_operand_a", operand_a, 32'd0);
      check("arst_operand_b", operand_b, 32'd0);
      check("arst_rd", out_rd, 5'd0);
      check("arst_sel", dut_sel, 5'b0);
      check("arst_in_ready", in_ready, 1'b1);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_out_valid", out_valid, 1'b0);
      out_ready = 1'b1;
      send(1'b0, 3'b010, 1'b0, 32'd9, 32'd0, 32'hFFFF_FFF0, 5'd30, 1'b0);
      check("slti_b", operand_b, 32'hFFFF_FFF0);
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule

// File: doc/alu_issue_reg.md
Name: alu_issue_reg

Overview:
- Registered issue stage directly upstream of the ALU in the RISC-V datapath.
- Accepts a decoded ALU instruction from the ID stage over a valid/ready handshake. Produces the one-hot ALU select lines and final operands (rs2 or immediate) from a pipeline register.
- Includes a 1-entry skid buffer so in_ready is registered. Throughput is 1 op/cycle, latency 1 cycle.

Parameters:
- WIDTH, 32, operand/data width; must match the ALU.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept; registered, equals NOT skid_full.
- in_is_rtype  in  1  1 = R-type (operand_b = rs2), 0 = I-type (operand_b = imm).
- in_funct3  in  3  RV32 funct3.
- in_funct7_5  in  1  instruction bit 30.
- in_rs1_data  in  WIDTH  rs1 value.
- in_rs2_data  in  WIDTH  rs2 value.
- in_imm  in  WIDTH  sign-extended immediate.
- in_rd  in  5  destination register.
- in_reg_write  in  1  writeback enable.
- flush  in  1  synchronous pipeline kill.
- out_valid  out  1  output op valid.
- out_ready  in  1  downstream (ALU/EX) accepts.
- operand_a  out  WIDTH  to ALU operand_a.
- operand_b  out  WIDTH  to ALU operand_b.
- alu_sel_add, alu_sel_sub, alu_sel_and, alu_sel_or, alu_sel_slt  out  1 each  one-hot ALU selects.
- out_rd  out  5  registered rd.
- out_reg_write  out  1  registered writeback enable.
- out_illegal  out  1  op not supported by ALU.

Behaviour:
- Decode happens on the input side; the decoded result is stored in the register.
  - funct3 000: alu_sel_sub if in_is_rtype AND in_funct7_5, else alu_sel_add. ADDI ignores bit 30.
  - funct3 111: alu_sel_and.
  - funct3 110: alu_sel_or.
  - funct3 010: alu_sel_slt.
  - Any other funct3, or R-type with funct7_5=1 and funct3 != 000: all selects 0, out_illegal=1, out_reg_write forced 0.
- Selects are gated by out_valid. When out_valid=0 all alu_sel_* = 0, so the ALU result is 0.
- operand_a = stored rs1; operand_b = stored rs2 if R-type else stored imm. Muxed before the register, no width change.
- Storage:
  - main register feeds the outputs; skid register is used only under backpressure.
  - Accept occurs when in_valid AND in_ready.
  - Drain occurs when out_valid AND out_ready.
  - main empty, or main draining this cycle: accepted op loads main.
  - main full and not draining: accepted op loads skid; in_ready=0 from next cycle.
  - main draining while skid full: skid moves to main; in_ready=1 from next cycle.
  - Skid full means in_ready=0, so no accept occurs that cycle.
- Stall: while out_valid=1 and out_ready=0, all outputs are held bit-stable.
- Flush: synchronous with priority over everything. At that edge main and skid valids clear and the same-cycle input is discarded. Next cycle out_valid=0, in_ready=1.
- Reset (asynchronous, rst_n low): all valids 0, in_ready=1, all data/select/flag outputs 0. Reset mid-transfer drops any held ops. Outputs stay 0 until the first accept after rst_n rises.
- Payload registers load only on accept/move, never otherwise.

Test Plan:
- After reset, ADD x3 with rs1=5, rs2=7, out_ready=1 -> one cycle later out_valid=1, alu_sel_add=1, operand_a=5, operand_b=7, out_rd=3.
- SUB R-type (funct7_5=1) rs1=10, rs2=10, then ADDI funct7_5=1 with imm=0xFFFFFFFF -> first op alu_sel_sub=1; second op alu_sel_add=1 with operand_b=0xFFFFFFFF.
- Back-to-back ops A, B, C with out_ready low for 3 cycles starting with A at output -> B goes to skid, in_ready=0 the cycle after B is accepted, C held upstream. Outputs stay on A while stalled. After release the order is A, B, C with no loss or duplication.
- funct3=001 (SLL) with in_reg_write=1 -> out_illegal=1, all selects 0, out_reg_write=0.
- Assert flush with main and skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1; none of the three ops ever appears.
- Drop rst_n asynchronously mid-stall -> outputs go to 0 immediately, without waiting for a clock edge. After release, in_ready=1, out_valid=0.
